// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath and the sequencer that feeds it.
package mac_pkg;

  // Operand/accumulator width shared by the MAC and its feeder.
  localparam int MAC_DATA_W = 32;

  // Feeder sequencing states.
  typedef enum logic [1:0] {
    CLR   = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/mac_feeder.sv
// Stream sequencer upstream of the MAC: registers operand pairs into the MAC,
// finds the end of each dot product (in_last or MAX_LEN), presents the MAC
// accumulator on a valid/ready result stream and clears the MAC between vectors.
module mac_feeder #(
  parameter int DATA_W  = mac_pkg::MAC_DATA_W,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              mac_clear,
  output logic              mac_enable,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [DATA_W-1:0] mac_accum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              err_overlen
);

  import mac_pkg::*;

  feeder_state_t    state;
  feeder_state_t    state_next;
  logic [CNT_W-1:0] elem_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             at_max;
  logic             vec_end;
  logic             forced_end;
  logic             out_hs;

  // Handshake decode and end-of-vector detection.
  always_comb begin
    in_ready   = (state == ACCUM);
    accept     = in_valid && in_ready;
    cnt_inc    = elem_cnt + CNT_W'(1);
    at_max     = (cnt_inc == CNT_W'(MAX_LEN));
    vec_end    = accept && (in_last || at_max);
    forced_end = accept && at_max && !in_last;
    out_hs     = (state == OUT) && out_ready;
  end

  // Next-state logic; the MAC is cleared in CLR and on the result handshake.
  always_comb begin
    state_next = state;
    mac_clear  = 1'b0;
    out_valid  = 1'b0;
    case (state)
      CLR: begin
        mac_clear  = 1'b1;
        state_next = ACCUM;
      end
      ACCUM: begin
        if (vec_end) begin
          state_next = DRAIN;
        end else begin
          state_next = ACCUM;
        end
      end
      DRAIN: begin
        state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        mac_clear = out_ready;
        if (out_ready) begin
          state_next = ACCUM;
        end else begin
          state_next = OUT;
        end
      end
      default: begin
        mac_clear  = 1'b1;
        state_next = CLR;
      end
    endcase
  end

  // Result passthrough: the MAC holds its sum while we sit in OUT.
  always_comb begin
    out_data  = mac_accum;
    out_count = elem_cnt;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLR;
    end else begin
      state <= state_next;
    end
  end

  // Operand pipeline: one accepted pair becomes one MAC enable cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_a      <= '0;
      mac_b      <= '0;
      mac_enable <= 1'b0;
    end else begin
      mac_enable <= accept;
      if (accept) begin
        mac_a <= in_a;
        mac_b <= in_b;
      end
    end
  end

  // Element counter: counts accepts, zeroed when the result is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_cnt <= '0;
    end else if (accept) begin
      elem_cnt <= cnt_inc;
    end else if (out_hs) begin
      elem_cnt <= '0;
    end
  end

  // Sticky flag for a vector cut short at MAX_LEN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overlen <= 1'b0;
    end else if (forced_end) begin
      err_overlen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder with a behavioural MAC alongside it and a
// dot-product reference model built from plain arithmetic.
module tb_mac_feeder;

  localparam int DW = 32;
  localparam int ML = 4;
  localparam int CW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_last;
  logic          mac_clear;
  logic          mac_enable;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [DW-1:0] mac_accum;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          err_overlen;

  int n_checks = 0;
  int n_pass   = 0;
  logic rand_ready = 1'b0;

  mac_feeder #(.DATA_W(DW), .MAX_LEN(ML)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_clear(mac_clear), .mac_enable(mac_enable),
    .mac_a(mac_a), .mac_b(mac_b), .mac_accum(mac_accum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count),
    .err_overlen(err_overlen)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: clear wins over enable.
  always @(posedge clk) begin
    if (mac_clear) mac_accum <= '0;
    else if (mac_enable) mac_accum <= mac_accum + mac_a * mac_b;
  end

  // Result monitor: records every completed output handshake.
  logic [DW+CW-1:0] got_q[$];
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) got_q.push_back({out_data, out_count});
  end

  // Reference model state.
  logic [DW+CW-1:0] exp_q[$];
  logic [DW-1:0]    m_sum;
  int               m_cnt;
  logic             exp_err;

  function automatic void model_elem(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic last);
    m_sum = m_sum + a * b;
    m_cnt = m_cnt + 1;
    if (last || m_cnt == ML) begin
      exp_q.push_back({m_sum, CW'(m_cnt)});
      if (!last) exp_err = 1'b1;
      m_sum = '0;
      m_cnt = 0;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_elem(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic last, input int gap);
    logic acc;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    model_elem(a, b, last);
    acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    check("accept_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_results();
    logic [DW+CW-1:0] g;
    logic [DW+CW-1:0] e;
    for (int k = 0; k < 200 && got_q.size() < exp_q.size(); k++) tick();
    check("result_timeout", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check("result_data", g[DW+CW-1:CW], e[DW+CW-1:CW]);
      check("result_count", g[CW-1:0], e[CW-1:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] ga [3];
    logic [4:0]    pat;
    logic          prev;
    int            idx;
    int            len;

    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    out_ready = 1'b1;
    m_sum = '0; m_cnt = 0; exp_err = 1'b0;

    // Reset values.
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_mac_enable", mac_enable, 1'b0);
    check("rst_mac_a", mac_a, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_count", out_count, '0);
    check("rst_err", err_overlen, 1'b0);
    check("rst_mac_clear", mac_clear, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("clr_in_ready", in_ready, 1'b0);
    check("clr_mac_clear", mac_clear, 1'b1);
    tick();
    @(negedge clk);
    check("first_ready", in_ready, 1'b1);
    tick();

    // Basic 3-element vector with latency check.
    send_elem(32'd1, 32'd4, 1'b0, 0);
    send_elem(32'd2, 32'd5, 1'b0, 0);
    send_elem(32'd3, 32'd6, 1'b1, 0);
    @(negedge clk);
    check("lat_drain_valid", out_valid, 1'b0);
    check("lat_drain_enable", mac_enable, 1'b1);
    check("lat_drain_ready", in_ready, 1'b0);
    @(negedge clk);
    check("lat_out_valid", out_valid, 1'b1);
    check("basic_data", out_data, 32'd32);
    check("basic_count", out_count, 3'd3);
    wait_results();

    // Back-pressure: result holds until out_ready.
    out_ready = 1'b0;
    send_elem(32'd1, 32'd4, 1'b0, 0);
    send_elem(32'd2, 32'd5, 1'b0, 0);
    send_elem(32'd3, 32'd6, 1'b1, 0);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, 32'd32);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_mac_clear", mac_clear, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_clear_pulse", mac_clear, 1'b1);
    tick();
    wait_results();
    @(negedge clk);
    check("bp_after_valid", out_valid, 1'b0);
    tick();
    send_elem(32'd2, 32'd7, 1'b1, 0);
    wait_results();

    // Gapped input: in_valid 1,0,0,1,1; enable follows accepts by one cycle.
    ga[0] = 32'd10; ga[1] = 32'd20; ga[2] = 32'd30;
    pat = 5'b11001;
    idx = 0;
    prev = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = pat[c];
      if (pat[c]) begin
        in_a = ga[idx]; in_b = 32'd1; in_last = (idx == 2);
        model_elem(ga[idx], 32'd1, idx == 2);
        idx++;
      end
      @(negedge clk);
      check("gap_enable", mac_enable, prev);
      check("gap_ready", in_ready, 1'b1);
      prev = pat[c];
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("gap_enable_last", mac_enable, prev);
    tick();
    wait_results();

    // Overlength: six ones, in_last only on the sixth.
    for (int i = 0; i < 6; i++) send_elem(32'd1, 32'd1, i == 5, 0);
    wait_results();
    check("overlen_err", err_overlen, 1'b1);

    // Modular wrap.
    send_elem(32'hFFFF_FFFF, 32'd2, 1'b1, 0);
    wait_results();

    // Randomized vectors with random gaps and random back-pressure.
    rand_ready = 1'b1;
    for (int v = 0; v < 25; v++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 0)
          send_elem(DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)), i == len - 1,
                    $urandom_range(0, 2));
        else
          send_elem($urandom, $urandom, i == len - 1, $urandom_range(0, 2));
      end
      wait_results();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    check("rand_err", err_overlen, exp_err);

    // Reset mid-vector: partial result discarded, MAC cleared after release.
    send_elem(32'd5, 32'd5, 1'b0, 0);
    send_elem(32'd6, 32'd6, 1'b0, 0);
    reset = 1'b0;
    #1;
    check("mid_in_ready", in_ready, 1'b0);
    check("mid_mac_enable", mac_enable, 1'b0);
    check("mid_mac_a", mac_a, '0);
    check("mid_mac_b", mac_b, '0);
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_out_count", out_count, '0);
    check("mid_err", err_overlen, 1'b0);
    check("mid_mac_clear", mac_clear, 1'b1);
    m_sum = '0; m_cnt = 0; exp_err = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1'b0);
    check("rel_mac_clear", mac_clear, 1'b1);
    tick();
    @(negedge clk);
    check("rel_ready", in_ready, 1'b1);
    tick();
    send_elem(32'd3, 32'd3, 1'b1, 0);
    wait_results();
    check("final_err", err_overlen, exp_err);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
